// File: rtl/acc_bias_gen_pkg.sv
// Shared constants, FSM state type and saturation limits for the
// accumulate-and-bias generator.
package acc_bias_gen_pkg;

    localparam int unsigned D_BW      = 8;
    localparam int unsigned P_BW      = 16;
    localparam int unsigned AB_BW     = 21;
    localparam int unsigned MAX_TERMS = 32;
    localparam int unsigned CNT_W     = $clog2(MAX_TERMS + 1);

    localparam logic signed [AB_BW-1:0] SAT_MAX = {1'b0, {(AB_BW-1){1'b1}}};
    localparam logic signed [AB_BW-1:0] SAT_MIN = {1'b1, {(AB_BW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        BIAS = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/acc_bias_lane.sv
// One lane: partial-sum accumulator, bias register and saturating
// bias adder with a registered output.
module acc_bias_lane #(
    parameter int D_BW  = acc_bias_gen_pkg::D_BW,
    parameter int P_BW  = acc_bias_gen_pkg::P_BW,
    parameter int AB_BW = acc_bias_gen_pkg::AB_BW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bias_load,
    input  logic signed [D_BW-1:0]  bias_in,
    input  logic                    acc_load,
    input  logic                    acc_add,
    input  logic signed [P_BW-1:0]  psum,
    input  logic                    out_en,
    output logic signed [AB_BW-1:0] acc_bias
);

    localparam logic signed [AB_BW-1:0] SAT_HI = {1'b0, {(AB_BW-1){1'b1}}};
    localparam logic signed [AB_BW-1:0] SAT_LO = {1'b1, {(AB_BW-1){1'b0}}};

    logic signed [AB_BW-1:0] acc;
    logic signed [D_BW-1:0]  bias;
    logic signed [AB_BW-1:0] psum_ext;
    logic signed [AB_BW:0]   sum_c;
    logic signed [AB_BW-1:0] sat_c;

    assign psum_ext = {{(AB_BW-P_BW){psum[P_BW-1]}}, psum};
    assign sum_c    = {acc[AB_BW-1], acc} + {{(AB_BW+1-D_BW){bias[D_BW-1]}}, bias};

    // One guard bit: overflow shows as disagreement between the top two bits.
    always_comb begin
        sat_c = sum_c[AB_BW-1:0];
        if (sum_c[AB_BW] != sum_c[AB_BW-1]) begin
            sat_c = sum_c[AB_BW] ? SAT_LO : SAT_HI;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            bias     <= '0;
            acc_bias <= '0;
        end else begin
            if (bias_load) begin
                bias <= bias_in;
            end
            if (acc_load) begin
                acc <= psum_ext;
            end else if (acc_add) begin
                acc <= acc + psum_ext;
            end
            if (out_en) begin
                acc_bias <= sat_c;
            end
        end
    end

endmodule

// File: rtl/acc_bias_gen.sv
// Three-lane accumulate-and-bias generator: sums partial-sum beats per
// window, adds a saturating bias and strobes the bound block once per window.
module acc_bias_gen #(
    parameter int D_BW      = acc_bias_gen_pkg::D_BW,
    parameter int P_BW      = acc_bias_gen_pkg::P_BW,
    parameter int AB_BW     = acc_bias_gen_pkg::AB_BW,
    parameter int MAX_TERMS = acc_bias_gen_pkg::MAX_TERMS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_bias_load,
    input  logic signed [D_BW-1:0]  i_bias0,
    input  logic signed [D_BW-1:0]  i_bias1,
    input  logic signed [D_BW-1:0]  i_bias2,
    input  logic                    i_psum_valid,
    input  logic                    i_psum_last,
    input  logic signed [P_BW-1:0]  i_psum0,
    input  logic signed [P_BW-1:0]  i_psum1,
    input  logic signed [P_BW-1:0]  i_psum2,
    output logic                    o_bound_en,
    output logic signed [AB_BW-1:0] o_acc_bias0,
    output logic signed [AB_BW-1:0] o_acc_bias1,
    output logic signed [AB_BW-1:0] o_acc_bias2,
    output logic                    o_busy,
    output logic                    o_err
);

    import acc_bias_gen_pkg::*;

    localparam int unsigned CW = $clog2(MAX_TERMS + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt_c;
    logic          at_max_c;
    logic          acc_load_c;
    logic          acc_add_c;
    logic          out_en_c;

    assign cnt_nxt_c  = cnt + CW'(1);
    assign at_max_c   = (cnt_nxt_c == CW'(MAX_TERMS));
    assign acc_load_c = i_psum_valid && ((state == IDLE) || (state == OUT));
    assign acc_add_c  = i_psum_valid && (state == ACC);
    assign out_en_c   = (state == BIAS);

    // Window control shared by all lanes; strobe and busy are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            o_bound_en <= 1'b0;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_bound_en <= 1'b0;
            o_busy     <= 1'b0;
            case (state)
                IDLE, OUT: begin
                    if (i_psum_valid) begin
                        cnt <= CW'(1);
                        if (i_psum_last) begin
                            state  <= BIAS;
                            o_busy <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end else begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                ACC: begin
                    if (i_psum_valid) begin
                        cnt <= cnt_nxt_c;
                        if (i_psum_last || at_max_c) begin
                            state  <= BIAS;
                            o_busy <= 1'b1;
                        end
                        if (!i_psum_last && at_max_c) begin
                            o_err <= 1'b1;
                        end
                    end
                end
                BIAS: begin
                    // A beat here has nowhere to go: drop it and flag.
                    state      <= OUT;
                    o_bound_en <= 1'b1;
                    if (i_psum_valid) begin
                        o_err <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    acc_bias_lane #(.D_BW(D_BW), .P_BW(P_BW), .AB_BW(AB_BW)) u_lane0 (
        .clk(clk), .rst(rst), .bias_load(i_bias_load), .bias_in(i_bias0),
        .acc_load(acc_load_c), .acc_add(acc_add_c), .psum(i_psum0),
        .out_en(out_en_c), .acc_bias(o_acc_bias0)
    );

    acc_bias_lane #(.D_BW(D_BW), .P_BW(P_BW), .AB_BW(AB_BW)) u_lane1 (
        .clk(clk), .rst(rst), .bias_load(i_bias_load), .bias_in(i_bias1),
        .acc_load(acc_load_c), .acc_add(acc_add_c), .psum(i_psum1),
        .out_en(out_en_c), .acc_bias(o_acc_bias1)
    );

    acc_bias_lane #(.D_BW(D_BW), .P_BW(P_BW), .AB_BW(AB_BW)) u_lane2 (
        .clk(clk), .rst(rst), .bias_load(i_bias_load), .bias_in(i_bias2),
        .acc_load(acc_load_c), .acc_add(acc_add_c), .psum(i_psum2),
        .out_en(out_en_c), .acc_bias(o_acc_bias2)
    );

endmodule

// File: tb/tb_acc_bias_gen.sv
// Directed bench for acc_bias_gen: a window-level model checked every cycle,
// plus literal expectations on the strobed results.
module tb_acc_bias_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_bias_load = 1'b0;
    logic signed [7:0]  i_bias0 = '0, i_bias1 = '0, i_bias2 = '0;
    logic i_psum_valid = 1'b0;
    logic i_psum_last = 1'b0;
    logic signed [15:0] i_psum0 = '0, i_psum1 = '0, i_psum2 = '0;
    logic o_bound_en;
    logic signed [20:0] o_acc_bias0, o_acc_bias1, o_acc_bias2;
    logic o_busy;
    logic o_err;

    acc_bias_gen dut (
        .clk(clk), .rst(rst), .i_bias_load(i_bias_load),
        .i_bias0(i_bias0), .i_bias1(i_bias1), .i_bias2(i_bias2),
        .i_psum_valid(i_psum_valid), .i_psum_last(i_psum_last),
        .i_psum0(i_psum0), .i_psum1(i_psum1), .i_psum2(i_psum2),
        .o_bound_en(o_bound_en),
        .o_acc_bias0(o_acc_bias0), .o_acc_bias1(o_acc_bias1), .o_acc_bias2(o_acc_bias2),
        .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Window-level model: sums beats of the open window, one idle-looking cycle
    // after close for the bias add, then the strobe.
    int m_acc[3], m_bias[3], m_out[3];
    int m_n = 0;
    bit m_closing = 1'b0, m_stb = 1'b0, m_err = 1'b0;

    function automatic int sat(input int v);
        if (v > 1048575) return 1048575;
        if (v < -1048576) return -1048576;
        return v;
    endfunction

    always @(posedge clk) begin
        int ps[3];
        cyc <= cyc + 1;
        ps[0] = int'(i_psum0); ps[1] = int'(i_psum1); ps[2] = int'(i_psum2);
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_acc[k] = 0; m_bias[k] = 0; m_out[k] = 0;
            end
            m_n = 0; m_closing = 1'b0; m_stb = 1'b0; m_err = 1'b0;
        end else begin
            m_stb = 1'b0;
            if (m_closing) begin
                for (int k = 0; k < 3; k++) m_out[k] = sat(m_acc[k] + m_bias[k]);
                m_stb = 1'b1;
                m_closing = 1'b0;
                if (i_psum_valid) m_err = 1'b1;
            end else if (i_psum_valid) begin
                for (int k = 0; k < 3; k++) m_acc[k] = (m_n == 0) ? ps[k] : m_acc[k] + ps[k];
                m_n++;
                if (i_psum_last || m_n == 32) begin
                    if (!i_psum_last) m_err = 1'b1;
                    m_closing = 1'b1;
                    m_n = 0;
                end
            end
            if (i_bias_load) begin
                m_bias[0] = int'(i_bias0); m_bias[1] = int'(i_bias1); m_bias[2] = int'(i_bias2);
            end
        end
    end

    // Strobe log for the literal checks.
    int sc[$], s0[$], s1[$], s2[$];

    always @(negedge clk) begin
        if (started) begin
            chk("bound_en", int'(o_bound_en), int'(m_stb));
            chk("busy", int'(o_busy), int'(m_closing));
            chk("err", int'(o_err), int'(m_err));
            chk("acc_bias0", int'(o_acc_bias0), m_out[0]);
            chk("acc_bias1", int'(o_acc_bias1), m_out[1]);
            chk("acc_bias2", int'(o_acc_bias2), m_out[2]);
            if (o_bound_en) begin
                sc.push_back(cyc);
                s0.push_back(int'(o_acc_bias0));
                s1.push_back(int'(o_acc_bias1));
                s2.push_back(int'(o_acc_bias2));
            end
        end
    end

    task automatic step(input bit v, input bit l, input int a, input int b, input int c);
        @(negedge clk);
        i_bias_load = 1'b0;
        i_psum_valid = v; i_psum_last = l;
        i_psum0 = 16'(a); i_psum1 = 16'(b); i_psum2 = 16'(c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic load_bias(input int a, input int b, input int c);
        @(negedge clk);
        i_psum_valid = 1'b0; i_psum_last = 1'b0;
        i_bias_load = 1'b1;
        i_bias0 = 8'(a); i_bias1 = 8'(b); i_bias2 = 8'(c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_psum_valid = 1'b0; i_psum_last = 1'b0; i_bias_load = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_strobe(input string name, input int idx, input int a, input int b, input int c);
        if (sc.size() <= idx) begin
            chk({name, "_present"}, sc.size(), idx + 1);
        end else begin
            chk({name, "_0"}, s0[idx], a);
            chk({name, "_1"}, s1[idx], b);
            chk({name, "_2"}, s2[idx], c);
        end
    endtask

    initial begin
        int last_cyc;
        int n0;
        @(posedge clk);
        started = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out0", int'(o_acc_bias0), 0);
        chk("rst_bound_en", int'(o_bound_en), 0);
        chk("rst_err", int'(o_err), 0);

        // Two-beat window, zero bias; strobe two cycles after the last beat.
        step(1'b1, 1'b0, 10, -20, 100);
        step(1'b1, 1'b1, 22, -170, 20);
        last_cyc = cyc;
        idle(3);
        chk_strobe("win_a", 0, 32, -190, 120);
        if (sc.size() > 0) chk("latency", sc[0] - last_cyc, 2);

        // Single beat with mixed-sign bias.
        load_bias(5, -3, -128);
        step(1'b1, 1'b1, -105, -30, 198);
        idle(3);
        chk_strobe("win_b", 1, -100, -33, 70);

        // Positive saturation on a full window.
        load_bias(127, 127, 127);
        for (int i = 0; i < 32; i++) step(1'b1, i == 31, 32767, 32767, 32767);
        idle(3);
        chk_strobe("sat_pos", 2, 1048575, 1048575, 1048575);
        chk("sat_pos_err", int'(o_err), 0);

        // Negative saturation.
        load_bias(-1, -1, -1);
        for (int i = 0; i < 32; i++) step(1'b1, i == 31, -32768, -32768, -32768);
        idle(3);
        chk_strobe("sat_neg", 3, -1048576, -1048576, -1048576);

        // Back-to-back: next window starts in the strobe cycle.
        step(1'b1, 1'b1, 1, 2, 3);
        idle(1);
        step(1'b1, 1'b0, 4, 5, 6);
        step(1'b1, 1'b1, 7, 8, 9);
        idle(3);
        chk_strobe("b2b_first", 4, 0, 1, 2);
        chk_strobe("b2b_second", 5, 10, 12, 14);
        if (sc.size() > 5) chk("b2b_spacing", sc[5] - sc[4], 3);
        chk("b2b_err", int'(o_err), 0);

        // Bias load during BIAS applies only to the following window.
        step(1'b1, 1'b1, 100, 100, 100);
        load_bias(50, 50, 50);
        idle(2);
        chk_strobe("late_bias", 6, 99, 99, 99);
        step(1'b1, 1'b1, 100, 100, 100);
        idle(3);
        chk_strobe("new_bias", 7, 150, 150, 150);

        // Stray last without valid does nothing.
        n0 = sc.size();
        step(1'b0, 1'b1, 500, 500, 500);
        idle(3);
        chk("stray_last", sc.size(), n0);

        // Beat in BIAS is dropped and flagged.
        step(1'b1, 1'b1, 1, 1, 1);
        step(1'b1, 1'b0, 9, 9, 9);
        idle(3);
        chk_strobe("drop", 9 - 1, 51, 51, 51);
        chk("drop_err", int'(o_err), 1);

        // Window overrun without last.
        do_reset();
        chk("clr_err", int'(o_err), 0);
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 1, -1, 2);
        idle(3);
        chk_strobe("overrun", 9, 32, -32, 64);
        chk("overrun_err", int'(o_err), 1);
        idle(5);
        chk("err_sticky", int'(o_err), 1);

        // Reset mid-window: no strobe, everything back to zero.
        n0 = sc.size();
        step(1'b1, 1'b0, 7, 7, 7);
        step(1'b1, 1'b0, 7, 7, 7);
        do_reset();
        idle(5);
        chk("midrst_strobes", sc.size(), n0);
        chk("midrst_out0", int'(o_acc_bias0), 0);
        chk("midrst_out2", int'(o_acc_bias2), 0);
        chk("midrst_err", int'(o_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
